// File: rtl/pcm_multichannel_onset_detector.sv
// pcm_multichannel_onset_detector: per-channel confirmed threshold onset timestamping with peak tracking and first-channel report
module pcm_multichannel_onset_detector #(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 16,
   parameter int TIME_W   = 32,
   parameter int ABS_MODE = 1,
   parameter int CONFIRM  = 2,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                         pcm_clk,
   input  logic                         reset_n,
   input  logic                         sample_valid,
   input  logic [CHANNELS*DATA_W-1:0]   pcm_data,
   input  logic [TIME_W-1:0]            sample_counter,
   input  logic signed [DATA_W-1:0]     threshold,
   input  logic                         arm,
   output logic [CHANNELS-1:0]          triggered,
   output logic [CHANNELS*TIME_W-1:0]   triggered_time,
   output logic [CHANNELS*DATA_W-1:0]   peak_value,
   output logic                         all_triggered,
   output logic                         all_done,
   output logic [CH_W-1:0]              first_channel,
   output logic                         any_triggered
);
   typedef enum logic [1:0] {ARMED, CONFIRMING, TRIGGERED} state_t;
   localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   logic [CHANNELS-1:0] trig_n;
   logic [CH_W-1:0]     first_n;
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      state_t                    st, st_n;
      logic [7:0]                run, run_n;
      logic [TIME_W-1:0]         cand_t, cand_t_n, t_q, t_n;
      logic signed [DATA_W-1:0]  x, v, cand_pk, cand_pk_n, pk, pk_n, cand_max, pk_max;
      logic                      hit;
      assign x        = pcm_data[k*DATA_W +: DATA_W];
      assign v        = (ABS_MODE == 0) ? x : !x[DATA_W-1] ? x : (x == S_MIN) ? S_MAX : -x;
      assign hit      = v > threshold;
      assign cand_max = (v > cand_pk) ? v : cand_pk;
      assign pk_max   = (v > pk) ? v : pk;
      always_comb begin
         st_n      = st;
         run_n     = run;
         cand_t_n  = cand_t;
         cand_pk_n = cand_pk;
         t_n       = t_q;
         pk_n      = pk;
         if (arm) begin
            st_n      = ARMED;
            run_n     = '0;
            cand_t_n  = '0;
            cand_pk_n = '0;
            t_n       = '0;
            pk_n      = '0;
         end else if (sample_valid) begin
            if (st == ARMED && hit) begin
               cand_t_n  = sample_counter;
               cand_pk_n = v;
               run_n     = 8'd1;
               st_n      = (CONFIRM == 1) ? TRIGGERED : CONFIRMING;
               t_n       = (CONFIRM == 1) ? sample_counter : t_q;
               pk_n      = (CONFIRM == 1) ? v : pk;
            end else if (st == CONFIRMING && !hit) begin
               st_n = ARMED;
            end else if (st == CONFIRMING) begin
               run_n     = run + 8'd1;
               cand_pk_n = cand_max;
               if (run + 8'd1 == 8'(CONFIRM)) begin
                  st_n = TRIGGERED;
                  t_n  = cand_t;
                  pk_n = cand_max;
               end
            end else if (st == TRIGGERED) begin
               pk_n = pk_max;
            end
         end
      end
      always_ff @(posedge pcm_clk or negedge reset_n) begin
         if (!reset_n) begin
            st      <= ARMED;
            run     <= '0;
            cand_t  <= '0;
            cand_pk <= '0;
            t_q     <= '0;
            pk      <= '0;
         end else begin
            st      <= st_n;
            run     <= run_n;
            cand_t  <= cand_t_n;
            cand_pk <= cand_pk_n;
            t_q     <= t_n;
            pk      <= pk_n;
         end
      end
      assign trig_n[k]                          = st_n == TRIGGERED;
      assign triggered[k]                       = st == TRIGGERED;
      assign triggered_time[k*TIME_W +: TIME_W] = t_q;
      assign peak_value[k*DATA_W +: DATA_W]     = pk;
   end
   // descending scan so the lowest simultaneous index wins
   always_comb begin
      first_n = '0;
      for (int i = CHANNELS - 1; i >= 0; i--)
         if (trig_n[i]) first_n = CH_W'(i);
   end
   assign any_triggered = |triggered;
   always_ff @(posedge pcm_clk or negedge reset_n) begin
      if (!reset_n) begin
         all_triggered <= 1'b0;
         all_done      <= 1'b0;
         first_channel <= '0;
      end else if (arm) begin
         all_triggered <= 1'b0;
         all_done      <= 1'b0;
         first_channel <= '0;
      end else begin
         all_triggered <= &triggered;
         all_done      <= &triggered & ~all_triggered;
         if (!any_triggered && |trig_n) first_channel <= first_n;
      end
   end
endmodule

// File: tb/tb_pcm_multichannel_onset_detector.sv
// tb_pcm_multichannel_onset_detector: directed checks with abs and signed compare instances
module tb_pcm_multichannel_onset_detector;
   logic               pcm_clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               sample_valid = 1'b0;
   logic [63:0]        pcm_data = '0;
   logic [31:0]        sample_counter = '0;
   logic signed [15:0] threshold = 16'sd1000;
   logic               arm = 1'b0;
   logic [3:0]         triggered, triggered_z;
   logic [127:0]       triggered_time, triggered_time_z;
   logic [63:0]        peak_value, peak_value_z;
   logic               all_triggered, all_done, any_triggered;
   logic               all_triggered_z, all_done_z, any_triggered_z;
   logic [1:0]         first_channel, first_channel_z;
   int                 errs = 0;
   int                 checks = 0;

   always #5 pcm_clk = ~pcm_clk;

   pcm_multichannel_onset_detector #(.CHANNELS(4), .DATA_W(16), .TIME_W(32), .ABS_MODE(1), .CONFIRM(2)) dut (
      .pcm_clk(pcm_clk), .reset_n(reset_n), .sample_valid(sample_valid), .pcm_data(pcm_data),
      .sample_counter(sample_counter), .threshold(threshold), .arm(arm), .triggered(triggered),
      .triggered_time(triggered_time), .peak_value(peak_value), .all_triggered(all_triggered),
      .all_done(all_done), .first_channel(first_channel), .any_triggered(any_triggered));

   pcm_multichannel_onset_detector #(.CHANNELS(4), .DATA_W(16), .TIME_W(32), .ABS_MODE(0), .CONFIRM(2)) dut_z (
      .pcm_clk(pcm_clk), .reset_n(reset_n), .sample_valid(sample_valid), .pcm_data(pcm_data),
      .sample_counter(sample_counter), .threshold(threshold), .arm(arm), .triggered(triggered_z),
      .triggered_time(triggered_time_z), .peak_value(peak_value_z), .all_triggered(all_triggered_z),
      .all_done(all_done_z), .first_channel(first_channel_z), .any_triggered(any_triggered_z));

   function automatic logic [63:0] pk4(input logic [15:0] c3, c2, c1, c0);
      return {c3, c2, c1, c0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic smp(input logic v, input logic [63:0] d, input logic [31:0] t, input logic a);
      sample_valid = v;
      pcm_data = d;
      sample_counter = t;
      arm = a;
      @(posedge pcm_clk);
      #1;
      sample_valid = 1'b0;
      arm = 1'b0;
   endtask

   task automatic chk_clear(input string tag);
      chk({tag, "_trig"}, 64'(triggered), 64'h0);
      chk({tag, "_any"}, 64'(any_triggered), 64'h0);
      chk({tag, "_all"}, 64'(all_triggered), 64'h0);
      chk({tag, "_done"}, 64'(all_done), 64'h0);
      chk({tag, "_first"}, 64'(first_channel), 64'h0);
      chk({tag, "_time_lo"}, triggered_time[63:0], 64'h0);
      chk({tag, "_time_hi"}, triggered_time[127:64], 64'h0);
      chk({tag, "_peak"}, peak_value, 64'h0);
   endtask

   initial begin
      @(posedge pcm_clk);
      #1;
      chk_clear("reset");
      reset_n = 1'b1;
      // single-channel crossing on ch1
      smp(1'b1, pk4(0, 0, 0, 0), 49, 1'b0);
      smp(1'b1, pk4(0, 0, 1200, 0), 50, 1'b0);
      chk("single_confirming", 64'(triggered), 64'h0);
      smp(1'b1, pk4(0, 0, 1300, 0), 51, 1'b0);
      chk("single_trig", 64'(triggered), 64'h2);
      chk("single_time1", 64'(triggered_time[63:32]), 64'd50);
      chk("single_first", 64'(first_channel), 64'd1);
      chk("single_peak1", 64'(peak_value[31:16]), 64'd1300);
      chk("single_any", 64'(any_triggered), 64'h1);
      chk("single_all", 64'(all_triggered), 64'h0);
      smp(1'b1, pk4(0, 0, 1400, 0), 52, 1'b0);
      chk("peak_rise", 64'(peak_value[31:16]), 64'd1400);
      smp(1'b1, pk4(0, 0, 500, 0), 53, 1'b0);
      chk("peak_hold", 64'(peak_value[31:16]), 64'd1400);
      smp(1'b0, '0, 54, 1'b1);
      chk_clear("arm1");
      // glitch rejection on ch0, with an invalid gap inside the confirming run
      smp(1'b1, pk4(0, 0, 0, 1500), 10, 1'b0);
      smp(1'b1, pk4(0, 0, 0, 0), 11, 1'b0);
      smp(1'b1, pk4(0, 0, 0, 1100), 12, 1'b0);
      smp(1'b0, pk4(0, 0, 0, 0), 99, 1'b0);
      chk("glitch_gap", 64'(triggered), 64'h0);
      smp(1'b1, pk4(0, 0, 0, 1100), 13, 1'b0);
      chk("glitch_trig", 64'(triggered), 64'h1);
      chk("glitch_time0", 64'(triggered_time[31:0]), 64'd12);
      chk("glitch_peak0", 64'(peak_value[15:0]), 64'd1100);
      chk("glitch_first", 64'(first_channel), 64'd0);
      smp(1'b0, '0, 0, 1'b1);
      // negative full-scale pulse on ch2
      smp(1'b1, pk4(0, 16'h8000, 0, 0), 7, 1'b0);
      smp(1'b1, pk4(0, 16'h8000, 0, 0), 8, 1'b0);
      chk("abs_trig", 64'(triggered), 64'h4);
      chk("abs_time2", 64'(triggered_time[95:64]), 64'd7);
      chk("abs_peak2", 64'(peak_value[47:32]), 64'd32767);
      chk("signed_no_trig", 64'(triggered_z), 64'h0);
      smp(1'b0, '0, 0, 1'b1);
      // ch2/ch3 simultaneous, then ch0/ch1
      smp(1'b1, pk4(3000, 2000, 0, 0), 19, 1'b0);
      smp(1'b1, pk4(2500, 2000, 0, 0), 20, 1'b0);
      chk("sim_trig", 64'(triggered), 64'hC);
      chk("sim_first", 64'(first_channel), 64'd2);
      chk("sim_peak3", 64'(peak_value[63:48]), 64'd3000);
      smp(1'b1, pk4(0, 0, 1200, 1100), 29, 1'b0);
      smp(1'b1, pk4(0, 0, 1200, 1100), 30, 1'b0);
      chk("sim_all_trig", 64'(triggered), 64'hF);
      chk("sim_all_early", 64'(all_triggered), 64'h0);
      chk("sim_done_early", 64'(all_done), 64'h0);
      chk("sim_first_hold", 64'(first_channel), 64'd2);
      smp(1'b0, '0, 31, 1'b0);
      chk("all_rise", 64'(all_triggered), 64'h1);
      chk("done_pulse", 64'(all_done), 64'h1);
      smp(1'b0, '0, 32, 1'b0);
      chk("all_level", 64'(all_triggered), 64'h1);
      chk("done_single", 64'(all_done), 64'h0);
      // arm collides with a hit sample
      smp(1'b1, pk4(5000, 5000, 5000, 5000), 40, 1'b1);
      chk_clear("arm_collide");
      smp(1'b1, pk4(0, 0, 0, 2000), 41, 1'b0);
      chk("collide_ignored", 64'(triggered), 64'h0);
      smp(1'b1, pk4(0, 0, 0, 2000), 42, 1'b0);
      chk("rearm_trig", 64'(triggered), 64'h1);
      chk("rearm_time0", 64'(triggered_time[31:0]), 64'd41);
      // async reset while ch1 is confirming
      smp(1'b1, pk4(0, 0, 1500, 0), 43, 1'b0);
      reset_n = 1'b0;
      #1;
      chk_clear("async_reset");
      #1;
      reset_n = 1'b1;
      smp(1'b1, pk4(0, 0, 1500, 0), 44, 1'b0);
      chk("post_reset_single", 64'(triggered), 64'h0);
      smp(1'b1, pk4(0, 0, 1500, 0), 45, 1'b0);
      chk("post_reset_trig", 64'(triggered), 64'h2);
      chk("post_reset_time1", 64'(triggered_time[63:32]), 64'd44);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
